cpu_step_clock: RTL and testbench
=================================

# cpu_step_clock

Clock-source stage that sits directly upstream of the pipelined MIPS core and generates the `clock` it runs on. It turns a board pushbutton into clean single-cycle steps, or free-runs at a slow divided rate, so the instruction shown on the seven-segment displays can be followed by eye. It also reports how many CPU cycles have been issued. `cpu_clock` is a registered output toggled by an FSM, not a gated clock.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 500000: consecutive board-clock cycles a key level must be stable before it is accepted (10 ms at 50 MHz).
- `HALF_PERIOD`, default 25000000: board-clock cycles per `cpu_clock` phase, high or low. Must be at least 1.
- `CNT_W`, default 16: width of `cycle_count`.

Ports:
- `clock` in 1: board clock.
- `reset` in 1: reset, asynchronous and active-low.
- `step_key` in 1: raw pushbutton, active-low (0 = pressed), asynchronous to `clock`.
- `run_mode` in 1: raw switch. 1 = free-run, 0 = single-step. Asynchronous.
- `cpu_clock` out 1: clock fed to the core's `clock` input.
- `cpu_tick` out 1: one board-cycle pulse marking each `cpu_clock` rising edge.
- `cycle_count` out CNT_W: number of `cpu_clock` rising edges issued since reset.

## Operation

Synchronizers:
- `step_key` and `run_mode` each pass through a 2-flop synchronizer.
- Reset values: 1 for the key path, 0 for the run path.

Debouncer:
- Holds `key_stable` (reset value 1) and a mismatch counter.
- Counter clears whenever the synced key equals `key_stable`.
- `key_stable` takes the synced value on the edge that completes `DEBOUNCE_CYCLES` consecutive mismatches; the counter clears at the same edge.
- `press_evt` = `key_stable` transition 1→0. It lasts exactly one cycle.

FSM states: IDLE, HIGH, LOW. A phase timer counts 0..HALF_PERIOD-1.
- IDLE: `cpu_clock`=0. Go to HIGH if `run_sync`=1, else if `press_evt`=1.
- HIGH: `cpu_clock`=1. After HALF_PERIOD cycles, go to LOW.
- LOW: `cpu_clock`=0. After HALF_PERIOD cycles, go to HIGH if `run_sync`=1, else go to IDLE.
- Every entry into HIGH:
  - loads the timer with 0;
  - asserts `cpu_tick` for that one cycle;
  - increments `cycle_count` modulo 2^CNT_W (all-ones wraps to 0).
- `press_evt` in HIGH or LOW is dropped, not queued.
- `run_mode` falling during HIGH or LOW: the current period completes in full, then the FSM goes to IDLE.
- `run_mode` rising in IDLE starts free-run within 3 edges, with no key press needed.
- `run_sync`=1 together with `press_evt` in IDLE: a single entry into HIGH, counted once.

Reset (asynchronous, `reset`=0):
- `cpu_clock`=0, `cpu_tick`=0, `cycle_count`=0.
- State IDLE, timer 0, debounce counter 0.
- Takes effect immediately, including mid-HIGH. On deassertion, operation resumes at the next `clock` edge.

## Timing

- All outputs are registered: no combinational path from inputs to outputs.
- Step latency: the first edge sampling `step_key`=0 is edge 0. `cpu_clock` rises on edge DEBOUNCE_CYCLES+3. The budget is 2 synchronizer edges, DEBOUNCE_CYCLES of filtering, and 1 FSM edge.
- Step pulse: high for exactly HALF_PERIOD cycles, then low for at least HALF_PERIOD cycles before another step is possible.
- Free-run: period is exactly 2·HALF_PERIOD, with 50% duty cycle.
- `cpu_tick` is high in the same cycle as the first high cycle of `cpu_clock`.
- `cycle_count` updates on that same edge.
- Key release is also debounced but produces no event.

## Test plan

All scenarios use DEBOUNCE_CYCLES=4, HALF_PERIOD=3, CNT_W=4.

- Reset: `reset`=0 at any time, including mid-HIGH → `cpu_clock`=0 immediately; `cycle_count`=0 and `cpu_tick`=0 until the first step after release.
- Clean step: hold `step_key`=0 for 20 cycles → `cpu_clock` rises on edge 7; it is high for 3 cycles, then low; exactly one `cpu_tick`; `cycle_count`=1.
- Bounce: `step_key` sequence 0,0,1,0,0,0,1 (each value held 1 cycle), then 1 → no `cpu_clock` pulse; `cycle_count`=0.
- Free-run: `run_mode`=1 for 40 cycles → `cpu_clock` is a period-6 square wave; `cycle_count` increments every 6 cycles; `cpu_tick` pulses are exactly 6 apart.
- Mode change and dropped press: drop `run_mode` mid-HIGH and press the key during that HIGH → the HIGH/LOW period completes, the FSM settles in IDLE, and there is no extra pulse. A fresh press afterwards gives exactly one pulse.
- Wrap: 17 single steps → `cycle_count` reads 0 after the 16th step and 1 after the 17th.

Source files
------------

// File: rtl/cpu_step_clock.sv
// -----------------------------------------------------------------------------
// cpu_step_clock
//
// Generates the clock for the pipelined MIPS core from the board clock.
// In single-step mode each debounced press of the step pushbutton produces
// exactly one cpu_clock pulse. In free-run mode cpu_clock is a slow square
// wave, so the instruction on the seven-segment displays can be followed by
// eye. cpu_clock is a registered FSM output, not a gated clock.
//
// Ports:
//   clock       in   board clock
//   reset       in   asynchronous, active-low reset
//   step_key    in   raw pushbutton, active-low, asynchronous to clock
//   run_mode    in   raw switch, 1 = free-run, 0 = single-step, asynchronous
//   cpu_clock   out  clock fed to the core
//   cpu_tick    out  one board-cycle pulse in the first high cycle of cpu_clock
//   cycle_count out  cpu_clock rising edges issued since reset (wraps)
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable cycles before a key level is accepted
//   HALF_PERIOD      board cycles per cpu_clock phase (>= 1)
//   CNT_W            width of cycle_count
// -----------------------------------------------------------------------------
module cpu_step_clock #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HALF_PERIOD     = 25000000,
  parameter int CNT_W           = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             step_key,
  input  logic             run_mode,
  output logic             cpu_clock,
  output logic             cpu_tick,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TM_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TM_W-1:0] TM_LAST = TM_W'(HALF_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  // Synchronizer flops
  logic key_meta_q, key_sync_q;
  logic run_meta_q, run_sync_q;

  // Debouncer
  logic            key_stable_q, key_stable_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            key_prev_q;
  logic            press_evt_q, press_evt_d;

  // Clock FSM
  state_e          state_q, state_d;
  logic [TM_W-1:0] timer_q, timer_d;
  logic            enter_high;

  // Registered outputs
  logic             cpu_clock_q, cpu_clock_d;
  logic             cpu_tick_q, cpu_tick_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Two-flop synchronizers. The key path resets to 1 (released) so that
  // leaving reset never looks like a press; the run path resets to 0 so the
  // core does not start free-running until the switch is actually seen.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      key_meta_q <= 1'b1;
      key_sync_q <= 1'b1;
      run_meta_q <= 1'b0;
      run_sync_q <= 1'b0;
    end else begin
      key_meta_q <= step_key;
      key_sync_q <= key_meta_q;
      run_meta_q <= run_mode;
      run_sync_q <= run_meta_q;
    end
  end

  // Debouncer: the counter tracks how many consecutive cycles the synced key
  // has disagreed with the accepted level. Any agreement restarts the count,
  // so bounces shorter than DEBOUNCE_CYCLES are swallowed entirely.
  always_comb begin
    db_cnt_d     = db_cnt_q;
    key_stable_d = key_stable_q;
    if (key_sync_q == key_stable_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      key_stable_d = key_sync_q;
      db_cnt_d     = '0;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  // The press event is taken from a delayed copy of the accepted level and
  // then registered, giving a clean single-cycle pulse on every 1->0
  // transition; release transitions produce nothing.
  always_comb begin
    press_evt_d = key_prev_q & ~key_stable_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      key_stable_q <= 1'b1;
      db_cnt_q     <= '0;
      key_prev_q   <= 1'b1;
      press_evt_q  <= 1'b0;
    end else begin
      key_stable_q <= key_stable_d;
      db_cnt_q     <= db_cnt_d;
      key_prev_q   <= key_stable_q;
      press_evt_q  <= press_evt_d;
    end
  end

  // Clock FSM next-state logic. IDLE waits for free-run or a press; HIGH and
  // LOW each last HALF_PERIOD cycles. A period is never cut short: run_mode
  // is only consulted at the end of LOW, and presses outside IDLE are simply
  // ignored. Every entry into HIGH funnels through enter_high so the tick and
  // the counter update come from one place.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    enter_high = 1'b0;

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (run_sync_q || press_evt_q) begin
          enter_high = 1'b1;
        end
      end

      HIGH: begin
        if (timer_q == TM_LAST) begin
          state_d = LOW;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      LOW: begin
        if (timer_q == TM_LAST) begin
          if (run_sync_q) begin
            enter_high = 1'b1;
          end else begin
            state_d = IDLE;
            timer_d = '0;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase

    if (enter_high) begin
      state_d = HIGH;
      timer_d = '0;
    end
  end

  // Output next-state: cpu_clock follows the state being entered so it is
  // aligned with the FSM, and the tick/count share the entry edge.
  always_comb begin
    cpu_clock_d = (state_d == HIGH);
    cpu_tick_d  = enter_high;
    count_d     = count_q;
    if (enter_high) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      cpu_clock_q <= 1'b0;
      cpu_tick_q  <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      cpu_clock_q <= cpu_clock_d;
      cpu_tick_q  <= cpu_tick_d;
      count_q     <= count_d;
    end
  end

  assign cpu_clock   = cpu_clock_q;
  assign cpu_tick    = cpu_tick_q;
  assign cycle_count = count_q;

endmodule

// File: tb/tb_cpu_step_clock.sv
// -----------------------------------------------------------------------------
// tb_cpu_step_clock
//
// Self-checking bench for cpu_step_clock with DEBOUNCE_CYCLES=4,
// HALF_PERIOD=3, CNT_W=4. A reference model predicts cpu_clock, cpu_tick and
// cycle_count on every board edge from the history of applied inputs; directed
// checks cover step latency, bounce rejection, free-run spacing, mode change,
// reset (including mid-HIGH) and counter wrap.
// -----------------------------------------------------------------------------
module tb_cpu_step_clock;

  localparam int D = 4;
  localparam int H = 3;
  localparam int W = 4;

  logic         clock;
  logic         reset;
  logic         stepKey;
  logic         runMode;
  logic         cpuClock;
  logic         cpuTick;
  logic [W-1:0] cycleCount;

  cpu_step_clock #(
    .DEBOUNCE_CYCLES(D),
    .HALF_PERIOD    (H),
    .CNT_W          (W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .step_key   (stepKey),
    .run_mode   (runMode),
    .cpu_clock  (cpuClock),
    .cpu_tick   (cpuTick),
    .cycle_count(cycleCount)
  );

  // Board clock, 10 time units per cycle
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  // Reference model state: input histories indexed by edge number since
  // reset release, plus the time-based description of the current period.
  bit keyHist[$];
  bit runHist[$];
  bit fallHist[$];
  int n;
  bit mStable;
  bit mActive;
  int mStart;
  int mCount;
  bit expClk;
  bit expTick;

  function automatic bit histKey(int i);
    return (i < 0) ? 1'b1 : keyHist[i];
  endfunction

  function automatic bit histRun(int i);
    return (i < 0) ? 1'b0 : runHist[i];
  endfunction

  function automatic bit histFall(int i);
    return (i < 0) ? 1'b0 : fallHist[i];
  endfunction

  // Comparison helper used at every check point
  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic modelReset();
    keyHist.delete();
    runHist.delete();
    fallHist.delete();
    n       = 0;
    mStable = 1'b1;
    mActive = 1'b0;
    mStart  = 0;
    mCount  = 0;
    expClk  = 1'b0;
    expTick = 1'b0;
  endtask

  // Model of one board edge n. The accepted key level flips once the last D
  // synchronized samples (input delayed by two edges) all disagree with it.
  // A fall becomes usable by the clock generator two edges later; a run
  // request likewise acts on the input sampled two edges earlier.
  task automatic modelEdge();
    bit flip;
    bit fell;
    bit start;
    flip = 1'b1;
    for (int j = 0; j < D; j++) begin
      if (histKey(n - 2 - j) == mStable) flip = 1'b0;
    end
    fell = flip && mStable;
    if (flip) mStable = ~mStable;
    fallHist.push_back(fell);

    start = 1'b0;
    if (mActive && n == mStart + 2 * H) begin
      if (histRun(n - 2)) start = 1'b1;
      else mActive = 1'b0;
    end else if (!mActive && (histRun(n - 2) || histFall(n - 2))) begin
      start = 1'b1;
    end
    if (start) begin
      mActive = 1'b1;
      mStart  = n;
      mCount  = (mCount + 1) % (1 << W);
    end
    expClk  = mActive && ((n - mStart) < H);
    expTick = start;
  endtask

  task automatic checkOutput();
    checkValue("cpu_clock", 32'(cpuClock), 32'(expClk));
    checkValue("cpu_tick", 32'(cpuTick), 32'(expTick));
    checkValue("cycle_count", 32'(cycleCount), 32'(mCount));
  endtask

  // Drive one cycle of inputs, let one edge pass, update model, compare
  task automatic applyStimulus(input bit k, input bit r);
    stepKey = k;
    runMode = r;
    keyHist.push_back(k);
    runHist.push_back(r);
    @(posedge clock);
    modelEdge();
    #1;
    checkOutput();
    n++;
  endtask

  // Assert reset between edges, check outputs drop at once, then release
  task automatic doReset(input string tag);
    #2;
    reset = 1'b0;
    #1;
    checkValue({tag, "_clk"}, 32'(cpuClock), 32'd0);
    checkValue({tag, "_tick"}, 32'(cpuTick), 32'd0);
    checkValue({tag, "_count"}, 32'(cycleCount), 32'd0);
    stepKey = 1'b1;
    runMode = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checkValue({tag, "_held"}, 32'(cpuClock), 32'd0);
    @(negedge clock);
    modelReset();
    reset = 1'b1;
  endtask

  initial begin
    int riseEdge;
    int highCycles;
    int ticks;
    int lastTick;
    int baseCount;
    bit gotTick;
    bit stepSeq[7];
    bit rk;
    bit rr;
    int len;

    stepSeq = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    reset   = 1'b0;
    stepKey = 1'b1;
    runMode = 1'b0;
    modelReset();
    #12;
    doReset("reset_initial");

    // Clean step: key held low 20 cycles
    riseEdge   = -1;
    highCycles = 0;
    ticks      = 0;
    for (int i = 0; i < 35; i++) begin
      applyStimulus((i < 20) ? 1'b0 : 1'b1, 1'b0);
      if (cpuClock === 1'b1) begin
        highCycles++;
        if (riseEdge < 0) riseEdge = n - 1;
      end
      if (cpuTick === 1'b1) ticks++;
    end
    checkValue("step_rise_edge", 32'(riseEdge), 32'd7);
    checkValue("step_high_cycles", 32'(highCycles), 32'(H));
    checkValue("step_ticks", 32'(ticks), 32'd1);
    checkValue("step_count", 32'(cycleCount), 32'd1);

    // Bounce shorter than the debounce window
    highCycles = 0;
    for (int i = 0; i < 22; i++) begin
      applyStimulus((i < 7) ? stepSeq[i] : 1'b1, 1'b0);
      if (cpuClock === 1'b1) highCycles++;
    end
    checkValue("bounce_high_cycles", 32'(highCycles), 32'd0);
    checkValue("bounce_count", 32'(cycleCount), 32'd1);

    // Free-run: ticks must be exactly 2*H apart
    lastTick = -1;
    ticks    = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, 1'b1);
      if (cpuTick === 1'b1) begin
        if (lastTick >= 0) checkValue("freerun_spacing", 32'(n - 1 - lastTick), 32'(2 * H));
        lastTick = n - 1;
        ticks++;
      end
    end
    checkValue("freerun_ticks", 32'(ticks), 32'd7);
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, 1'b0);

    // Mode change mid-HIGH with a press that lands inside the active period
    gotTick = 1'b0;
    for (int i = 0; i < 20 && !gotTick; i++) begin
      applyStimulus(1'b1, 1'b1);
      if (cpuTick === 1'b1) gotTick = 1'b1;
    end
    checkValue("modechg_tick_seen", 32'(gotTick), 32'd1);
    baseCount = int'(cycleCount);
    for (int i = 1; i <= 30; i++) begin
      applyStimulus((i <= 10) ? 1'b0 : 1'b1, (i <= 7) ? 1'b1 : 1'b0);
    end
    checkValue("modechg_count", 32'(cycleCount), 32'((baseCount + 1) % (1 << W)));
    checkValue("modechg_idle", 32'(cpuClock), 32'd0);
    for (int i = 0; i < 25; i++) applyStimulus((i < 8) ? 1'b0 : 1'b1, 1'b0);
    checkValue("fresh_press_count", 32'(cycleCount), 32'((baseCount + 2) % (1 << W)));

    // Reset while cpu_clock is high
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1);
    checkValue("pre_reset_high", 32'(cpuClock), 32'd1);
    doReset("reset_mid_high");

    // Wrap: 17 single steps from a fresh reset
    for (int s = 1; s <= 17; s++) begin
      for (int i = 0; i < 18; i++) applyStimulus((i < 6) ? 1'b0 : 1'b1, 1'b0);
      if (s == 16) checkValue("wrap_after_16", 32'(cycleCount), 32'd0);
      if (s == 17) checkValue("wrap_after_17", 32'(cycleCount), 32'd1);
    end

    // Randomized key and run activity against the model
    for (int seg = 0; seg < 80; seg++) begin
      rk  = 1'($urandom % 2);
      rr  = (($urandom % 6) == 0);
      len = int'($urandom_range(1, 9));
      for (int i = 0; i < len; i++) applyStimulus(rk, rr);
    end
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
